// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM state type and limits for data_mem_unit.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WAIT_STATES_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/data_mem_unit_if.sv
// rtl/data_mem_unit_if.sv - request/response bus between the datapath and data_mem_unit.
interface data_mem_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - big-endian byte/half lane placement and load extension.
// Only built when DMEM_SUBWORD_EN is defined.
`ifdef DMEM_SUBWORD_EN
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        zext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wmask,
  output logic [31:0] wshift,
  output logic [31:0] rdata
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Big-endian: offset 0 is the most significant lane.
  assign byte_sh = {~off, 3'b000};
  assign half_sh = {~off[1], 4'b0000};
  assign lane_b  = 8'(rword >> byte_sh);
  assign lane_h  = 16'(rword >> half_sh);

  always_comb begin
    wmask  = '1;
    wshift = wdata;
    rdata  = rword;
    case (size)
      SZ_BYTE: begin
        wmask  = 32'h0000_00FF << byte_sh;
        wshift = {24'b0, wdata[7:0]} << byte_sh;
        rdata  = zext ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        wmask  = 32'h0000_FFFF << half_sh;
        wshift = {16'b0, wdata[15:0]} << half_sh;
        rdata  = zext ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

endmodule
`endif

// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - wait-stated data memory with error reporting.
// DMEM_SUBWORD_EN adds byte/half access with sign/zero extension.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_unit_if.slave bus
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              cur_we;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [ADDR_W-1:0] word_idx;
  logic              size_err, mis_err, oor_err, acc_err;
  logic              fire;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rword, wmask, wshift, ldata;

  // With zero wait states the access commits on the accept edge, so the live
  // request is used in IDLE; otherwise the latched copy is.
  assign cur_we    = (state == IDLE) ? bus.req_we    : lat_we;
  assign cur_size  = (state == IDLE) ? bus.req_size  : lat_size;
  assign cur_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;

  assign word_idx = cur_addr >> OFF_W;
  assign oor_err  = word_idx >= ADDR_W'(DEPTH);
  assign rword    = mem[word_idx[IDX_W-1:0]];
  assign acc_err  = size_err | mis_err | oor_err;

  assign fire = rst_n && (((state == IDLE) && bus.req_valid && (WAIT_STATES == 0)) ||
                          ((state == WAIT) && (cnt == 4'd0)));

`ifdef DMEM_SUBWORD_EN
  logic lat_uns;
  logic cur_uns;

  assign cur_uns  = (state == IDLE) ? bus.req_unsigned : lat_uns;
  assign size_err = (cur_size == 2'b11);
  assign mis_err  = ((cur_size == SZ_HALF) && cur_addr[0]) ||
                    ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lat_uns <= 1'b0;
    else if ((state == IDLE) && bus.req_valid)
      lat_uns <= bus.req_unsigned;
  end

  dmem_lane_align u_lane_align (
    .size   (cur_size),
    .off    (cur_addr[1:0]),
    .zext   (cur_uns),
    .wdata  (cur_wdata),
    .rword  (rword),
    .wmask  (wmask),
    .wshift (wshift),
    .rdata  (ldata)
  );
`else
  assign size_err = (cur_size != SZ_WORD);
  assign mis_err  = (cur_addr & ADDR_W'(DATA_W / 8 - 1)) != '0;
  assign wmask    = '1;
  assign wshift   = cur_wdata;
  assign ldata    = rword;
`endif

  always_ff @(posedge clk) begin
    if (fire && cur_we && !acc_err)
      mem[word_idx[IDX_W-1:0]] <= (rword & ~wmask) | (wshift & wmask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_size  <= 2'b00;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.req_valid) begin
        cnt       <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
        lat_we    <= bus.req_we;
        lat_size  <= bus.req_size;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (fire) begin
        rdata_q <= (acc_err || cur_we) ? '0 : ldata;
        err_q   <= acc_err;
      end
    end
  end

endmodule
